// File: rtl/port_rd_deserializer.sv
// Collects port-tagged serial read responses into three slots and presents them as one aligned group.
// Optional forced close of stale partial groups: define PORT_RD_DESER_TIMEOUT_EN.
module port_rd_deserializer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sin_data,
  input  logic             sin_valid,
  input  logic [1:0]       sin_port,
  input  logic             sin_last,
  output logic             sin_stall,
  input  logic             out_ready,
  output logic             out_group_valid,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  output logic             err_port,
  output logic             timeout_flag
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [2:0][WIDTH-1:0]   slot_data;
  logic [2:0]              slot_vld;
  logic [2:0]              sel;
  logic                    collecting, consume, close_beat, force_to, err_nxt;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign collecting = (state == COLLECT);
  assign consume    = (state == HOLD) && out_ready;
  assign close_beat = collecting && sin_valid && sin_last;
  assign sel        = {sin_port == 2'd3, sin_port == 2'd2, sin_port == 2'd1};

  // Illegal tag, duplicate tag within a group, or any beat presented while stalled
  assign err_nxt = sin_valid && (!collecting || (sin_port == 2'd0) || |(slot_vld & sel));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= COLLECT;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (close_beat || force_to) state_nxt = HOLD;
      HOLD:    if (out_ready)              state_nxt = COLLECT;
      default:                             state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    sin_stall       = (state == HOLD);
    out_group_valid = (state == HOLD);
  end

  for (genvar k = 0; k < 3; k++) begin : g_slot
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        slot_data[k] <= '0;
        slot_vld[k]  <= 1'b0;
      end else if (consume) begin
        slot_data[k] <= '0;
        slot_vld[k]  <= 1'b0;
      end else if (collecting && sin_valid && sel[k]) begin
        slot_data[k] <= sin_data;
        slot_vld[k]  <= 1'b1;
      end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_port <= 1'b0;
    else          err_port <= err_nxt;

`ifdef PORT_RD_DESER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  logic [CW-1:0] to_cnt;
  logic          to_flag;
  logic          idle_wait;

  // Counts idle edges of a partially filled group; the TIMEOUT-th one closes it
  assign idle_wait = collecting && |slot_vld && !sin_valid;
  assign force_to  = idle_wait && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                               to_cnt <= '0;
    else if (!collecting || sin_valid || force_to) to_cnt <= '0;
    else if (idle_wait)                         to_cnt <= to_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)      to_flag <= 1'b0;
    else if (consume)  to_flag <= 1'b0;
    else if (force_to) to_flag <= 1'b1;

  assign timeout_flag = to_flag;
`else
  assign force_to     = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign out1_data  = slot_data[0];
  assign out2_data  = slot_data[1];
  assign out3_data  = slot_data[2];
  assign out1_valid = slot_vld[0];
  assign out2_valid = slot_vld[1];
  assign out3_valid = slot_vld[2];

endmodule

// File: tb/tb_port_rd_deserializer.sv
// Directed bench for port_rd_deserializer with a queue of expected groups.
module tb_port_rd_deserializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sin_data = '0;
  logic       sin_valid = 1'b0;
  logic [1:0] sin_port = '0;
  logic       sin_last = 1'b0;
  logic       sin_stall;
  logic       out_ready = 1'b0;
  logic       out_group_valid;
  logic [7:0] out1_data, out2_data, out3_data;
  logic       out1_valid, out2_valid, out3_valid;
  logic       err_port, timeout_flag;

  port_rd_deserializer #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .sin_data(sin_data), .sin_valid(sin_valid), .sin_port(sin_port), .sin_last(sin_last),
    .sin_stall(sin_stall), .out_ready(out_ready), .out_group_valid(out_group_valid),
    .out1_data(out1_data), .out2_data(out2_data), .out3_data(out3_data),
    .out1_valid(out1_valid), .out2_valid(out2_valid), .out3_valid(out3_valid),
    .err_port(err_port), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][7:0] d;
    logic [2:0]      v;
    logic            tf;
  } grp_t;

  grp_t            q[$];
  logic [2:0][7:0] md = '0;
  logic [2:0]      mv = '0;
  logic            exp_err = 1'b0;
  int              checks = 0;
  int              failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_model(input logic tf);
    q.push_back('{d: md, v: mv, tf: tf});
    md = '0;
    mv = '0;
  endtask

  // One beat in COLLECT; the model predicts slot contents and the err pulse
  task automatic send(input int port, input logic [7:0] data, input logic last);
    sin_valid = 1'b1;
    sin_port  = 2'(port);
    sin_data  = data;
    sin_last  = last;
    if (port == 0) exp_err = 1'b1;
    else begin
      exp_err      = mv[port-1];
      md[port-1]   = data;
      mv[port-1]   = 1'b1;
    end
    if (last) push_model(1'b0);
    tick();
    sin_valid = 1'b0;
    sin_last  = 1'b0;
    chk("err_port", 32'(err_port), 32'(exp_err));
  endtask

  task automatic check_group(input string tag);
    grp_t g;
    int   n = 0;
    while (!out_group_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".group_valid"}, 32'(out_group_valid), 32'd1);
    chk({tag, ".stall"}, 32'(sin_stall), 32'd1);
    chk({tag, ".queued"}, 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) begin
      g = q[0];
      chk({tag, ".d1"}, 32'(out1_data), 32'(g.d[0]));
      chk({tag, ".d2"}, 32'(out2_data), 32'(g.d[1]));
      chk({tag, ".d3"}, 32'(out3_data), 32'(g.d[2]));
      chk({tag, ".v"}, 32'({out3_valid, out2_valid, out1_valid}), 32'(g.v));
      chk({tag, ".tf"}, 32'(timeout_flag), 32'(g.tf));
    end
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    chk({tag, ".gv_after"}, 32'(out_group_valid), 32'd0);
    chk({tag, ".stall_after"}, 32'(sin_stall), 32'd0);
    chk({tag, ".v_after"}, 32'({out3_valid, out2_valid, out1_valid}), 32'd0);
    chk({tag, ".tf_after"}, 32'(timeout_flag), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".gv"}, 32'(out_group_valid), 32'd0);
    chk({tag, ".stall"}, 32'(sin_stall), 32'd0);
    chk({tag, ".err"}, 32'(err_port), 32'd0);
    chk({tag, ".tf"}, 32'(timeout_flag), 32'd0);
    chk({tag, ".v"}, 32'({out3_valid, out2_valid, out1_valid}), 32'd0);
    chk({tag, ".d"}, 32'({out3_data, out2_data, out1_data}), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Three-port group, consumer always ready
    out_ready = 1'b1;
    send(1, 8'h11, 1'b0);
    chk("t1.gv_mid", 32'(out_group_valid), 32'd0);
    send(2, 8'h22, 1'b0);
    send(3, 8'h33, 1'b1);
    check_group("t1");
    accept("t1");

    // Single beat held under back-pressure for five cycles
    send(2, 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_group("t2.hold");
      tick();
    end
    check_group("t2.last");
    accept("t2");

    // Duplicate tag: newer beat wins, one-cycle err pulse
    send(1, 8'h01, 1'b0);
    send(1, 8'h02, 1'b1);
    check_group("t3");
    tick();
    chk("t3.err_one_cycle", 32'(err_port), 32'd0);
    accept("t3");

    // Tag 0 dropped; tag 0 with last closes an empty group
    send(0, 8'h99, 1'b0);
    tick();
    chk("t4.err_clear", 32'(err_port), 32'd0);
    chk("t4.dropped", 32'({out3_valid, out2_valid, out1_valid}), 32'd0);
    send(0, 8'h77, 1'b1);
    check_group("t4.empty");
    accept("t4");

    // Beat during HOLD: ignored, err pulse, contents unchanged
    send(1, 8'h10, 1'b0);
    send(3, 8'h30, 1'b1);
    check_group("t5.pre");
    sin_valid = 1'b1; sin_port = 2'd1; sin_data = 8'hFF;
    tick();
    sin_valid = 1'b0;
    chk("t5.err_hold", 32'(err_port), 32'd1);
    check_group("t5.post");
    accept("t5");

    // Stale partial group
    send(3, 8'h5C, 1'b0);
`ifdef PORT_RD_DESER_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t6.to_edge", 32'(out_group_valid), 32'(i == 16));
    end
    push_model(1'b1);
    check_group("t6.timeout");
    accept("t6");
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("t6.no_to", 32'(out_group_valid), 32'd0);
    end
    send(1, 8'h5D, 1'b1);
    check_group("t6.closed");
    accept("t6");
`endif

    // Asynchronous reset mid-group
    send(1, 8'hAA, 1'b0);
    reset_n = 1'b0;
    #1;
    check_all_zero("t7.mid");
    md = '0; mv = '0; q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Asynchronous reset in HOLD, then a clean group
    send(2, 8'hBB, 1'b1);
    check_group("t8.pre");
    reset_n = 1'b0;
    #1;
    check_all_zero("t8.hold");
    md = '0; mv = '0; q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    send(3, 8'hC3, 1'b1);
    check_group("t8.clean");
    accept("t8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
